// File: rtl/register_scoreboard_if.sv
// Decode/writeback bundle for register_scoreboard.
// Master drives issue and retire requests; slave (the scoreboard) returns stall and status.
interface register_scoreboard_if #(
  parameter int unsigned ADDR_W = 5
) ();
  logic              flush;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_d;
  logic [ADDR_W-1:0] issue_s;
  logic [ADDR_W-1:0] issue_t;
  logic [9:0]        issue_use;
  logic              issue_stall;
  logic              wb_gd_valid;
  logic [ADDR_W-1:0] wb_gd_idx;
  logic              wb_fd_valid;
  logic [ADDR_W-1:0] wb_fd_idx;
  logic              wb_ef_valid;
  logic              busy;
  logic              underflow_err;

  modport master (
    output flush, issue_valid, issue_d, issue_s, issue_t, issue_use,
    output wb_gd_valid, wb_gd_idx, wb_fd_valid, wb_fd_idx, wb_ef_valid,
    input  issue_stall, busy, underflow_err
  );

  modport slave (
    input  flush, issue_valid, issue_d, issue_s, issue_t, issue_use,
    input  wb_gd_valid, wb_gd_idx, wb_fd_valid, wb_fd_idx, wb_ef_valid,
    output issue_stall, busy, underflow_err
  );
endinterface

// File: rtl/register_scoreboard.sv
// Register scoreboard: per-register pending-write counters for GPRs, FPRs and EFLAGS.
// Stalls decode on read-after-write hazards and on counter saturation.
// Optional macro SCOREBOARD_WB_BYPASS_EN: hazards see the count net of same-cycle retires,
// so a consumer can issue in the writeback cycle of its last pending producer.
module register_scoreboard #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned GREG_N = 32,
  parameter int unsigned FREG_N = 32,
  parameter int unsigned CNT_W  = 2
) (
  input logic                  clk,
  input logic                  rst,
  register_scoreboard_if.slave io_bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_gcnt [GREG_N];
  logic [CNT_W-1:0] r_fcnt [FREG_N];
  logic [CNT_W-1:0] r_ecnt;
  logic             r_err;
  logic             r_busy;

  logic [CNT_W-1:0] w_gcnt_d [GREG_N];
  logic [CNT_W-1:0] w_fcnt_d [FREG_N];
  logic [CNT_W-1:0] w_ecnt_d;
  logic             w_err_d;
  logic             w_busy_d;

  logic w_from_gd, w_from_fd, w_to_gd, w_to_fd, w_from_gs;
  logic w_from_fs, w_from_gt, w_from_ft, w_from_ef, w_to_ef;

  assign {w_from_gd, w_from_fd, w_to_gd, w_to_fd, w_from_gs,
          w_from_fs, w_from_gt, w_from_ft, w_from_ef, w_to_ef} = io_bus.issue_use;

  // Indices beyond the tracked register count are ignored entirely.
  logic w_d_gok, w_s_gok, w_t_gok, w_d_fok, w_s_fok, w_t_fok, w_gwb_ok, w_fwb_ok;

  assign w_d_gok  = 32'(io_bus.issue_d) < GREG_N;
  assign w_s_gok  = 32'(io_bus.issue_s) < GREG_N;
  assign w_t_gok  = 32'(io_bus.issue_t) < GREG_N;
  assign w_d_fok  = 32'(io_bus.issue_d) < FREG_N;
  assign w_s_fok  = 32'(io_bus.issue_s) < FREG_N;
  assign w_t_fok  = 32'(io_bus.issue_t) < FREG_N;
  assign w_gwb_ok = io_bus.wb_gd_valid & (32'(io_bus.wb_gd_idx) < GREG_N);
  assign w_fwb_ok = io_bus.wb_fd_valid & (32'(io_bus.wb_fd_idx) < FREG_N);

  // Counts seen by the hazard logic (optionally net of same-cycle retires).
  logic [CNT_W-1:0] w_g_d, w_g_s, w_g_t, w_f_d, w_f_s, w_f_t, w_e;
  // Registered counts at the retire indices, used for underflow detection.
  logic [CNT_W-1:0] w_g_wb, w_f_wb;

  // Look up counters for the issuing instruction and the retiring writes.
  always_comb begin
    w_g_d  = w_d_gok  ? r_gcnt[io_bus.issue_d]   : '0;
    w_g_s  = w_s_gok  ? r_gcnt[io_bus.issue_s]   : '0;
    w_g_t  = w_t_gok  ? r_gcnt[io_bus.issue_t]   : '0;
    w_f_d  = w_d_fok  ? r_fcnt[io_bus.issue_d]   : '0;
    w_f_s  = w_s_fok  ? r_fcnt[io_bus.issue_s]   : '0;
    w_f_t  = w_t_fok  ? r_fcnt[io_bus.issue_t]   : '0;
    w_e    = r_ecnt;
    w_g_wb = w_gwb_ok ? r_gcnt[io_bus.wb_gd_idx] : '0;
    w_f_wb = w_fwb_ok ? r_fcnt[io_bus.wb_fd_idx] : '0;
`ifdef SCOREBOARD_WB_BYPASS_EN
    if (w_gwb_ok && io_bus.wb_gd_idx == io_bus.issue_d && w_g_d != '0) w_g_d = w_g_d - CNT_W'(1);
    if (w_gwb_ok && io_bus.wb_gd_idx == io_bus.issue_s && w_g_s != '0) w_g_s = w_g_s - CNT_W'(1);
    if (w_gwb_ok && io_bus.wb_gd_idx == io_bus.issue_t && w_g_t != '0) w_g_t = w_g_t - CNT_W'(1);
    if (w_fwb_ok && io_bus.wb_fd_idx == io_bus.issue_d && w_f_d != '0) w_f_d = w_f_d - CNT_W'(1);
    if (w_fwb_ok && io_bus.wb_fd_idx == io_bus.issue_s && w_f_s != '0) w_f_s = w_f_s - CNT_W'(1);
    if (w_fwb_ok && io_bus.wb_fd_idx == io_bus.issue_t && w_f_t != '0) w_f_t = w_f_t - CNT_W'(1);
    if (io_bus.wb_ef_valid && w_e != '0) w_e = w_e - CNT_W'(1);
`endif
  end

  logic w_raw, w_full, w_stall, w_accept;

  // Hazards use pre-issue counts, so an instruction never stalls on its own destination.
  assign w_raw = (w_from_gd & (w_g_d != '0)) | (w_from_fd & (w_f_d != '0)) |
                 (w_from_gs & (w_g_s != '0)) | (w_from_fs & (w_f_s != '0)) |
                 (w_from_gt & (w_g_t != '0)) | (w_from_ft & (w_f_t != '0)) |
                 (w_from_ef & (w_e != '0));

  assign w_full = (w_to_gd & w_d_gok & (w_g_d == CNT_MAX)) |
                  (w_to_fd & w_d_fok & (w_f_d == CNT_MAX)) |
                  (w_to_ef & (w_e == CNT_MAX));

  assign w_stall  = io_bus.issue_valid & (w_raw | w_full) & ~io_bus.flush;
  assign w_accept = io_bus.issue_valid & ~(w_raw | w_full) & ~io_bus.flush;

  // Next counter values: +1 on accepted issue, -1 on retire of a nonzero count; flush clears.
  always_comb begin
    w_busy_d = 1'b0;
    for (int unsigned i = 0; i < GREG_N; i++) begin
      w_gcnt_d[i] = r_gcnt[i]
        + CNT_W'(w_accept & w_to_gd & w_d_gok & (32'(io_bus.issue_d) == i))
        - CNT_W'(w_gwb_ok & (32'(io_bus.wb_gd_idx) == i) & (r_gcnt[i] != '0));
      if (io_bus.flush) w_gcnt_d[i] = '0;
      w_busy_d = w_busy_d | (w_gcnt_d[i] != '0);
    end
    for (int unsigned i = 0; i < FREG_N; i++) begin
      w_fcnt_d[i] = r_fcnt[i]
        + CNT_W'(w_accept & w_to_fd & w_d_fok & (32'(io_bus.issue_d) == i))
        - CNT_W'(w_fwb_ok & (32'(io_bus.wb_fd_idx) == i) & (r_fcnt[i] != '0));
      if (io_bus.flush) w_fcnt_d[i] = '0;
      w_busy_d = w_busy_d | (w_fcnt_d[i] != '0);
    end
    w_ecnt_d = r_ecnt + CNT_W'(w_accept & w_to_ef)
             - CNT_W'(io_bus.wb_ef_valid & (r_ecnt != '0));
    if (io_bus.flush) w_ecnt_d = '0;
    w_busy_d = w_busy_d | (w_ecnt_d != '0);
    // A flushed cycle's retires are ignored, so they cannot raise the error either.
    w_err_d = r_err | (~io_bus.flush & ((w_gwb_ok & (w_g_wb == '0)) |
                                        (w_fwb_ok & (w_f_wb == '0)) |
                                        (io_bus.wb_ef_valid & (r_ecnt == '0))));
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gcnt <= '{default: '0};
      r_fcnt <= '{default: '0};
      r_ecnt <= '0;
      r_err  <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_gcnt <= w_gcnt_d;
      r_fcnt <= w_fcnt_d;
      r_ecnt <= w_ecnt_d;
      r_err  <= w_err_d;
      r_busy <= w_busy_d;
    end
  end

  assign io_bus.issue_stall   = w_stall;
  assign io_bus.busy          = r_busy;
  assign io_bus.underflow_err = r_err;

endmodule

// File: doc/register_scoreboard.md
Name: register_scoreboard

Overview:
- Tracks in-flight register writes between decode and writeback. Consumes the per-instruction register usage record (dest/src indices plus from_/to_ flags) and raises a stall when a read or write would hit a hazard.
- Sits between the decode stage, which issues, and the writeback stage, which retires.
- Keeps one pending-write counter per GPR, one per FPR, and one for EFLAGS.

Parameters:
ADDR_W, 5, register index width (d, s, t fields)
GREG_N, 32, number of general registers tracked
FREG_N, 32, number of float registers tracked
CNT_W, 2, pending counter width per register; max in-flight writes per register = 2**CNT_W-1

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high; clears all state
flush  in  1  synchronous kill of all in-flight writes
issue_valid  in  1  decode presents an instruction
issue_d  in  ADDR_W  destination index
issue_s  in  ADDR_W  source s index
issue_t  in  ADDR_W  source t index
issue_use  in  10  {from_gd,from_fd,to_gd,to_fd,from_gs,from_fs,from_gt,from_ft,from_ef,to_ef}, MSB first
issue_stall  out  1  instruction must be held; issue accepted iff issue_valid & ~issue_stall
wb_gd_valid  in  1  a GPR write retires
wb_gd_idx  in  ADDR_W  its index
wb_fd_valid  in  1  an FPR write retires
wb_fd_idx  in  ADDR_W  its index
wb_ef_valid  in  1  an EFLAGS write retires
busy  out  1  any counter nonzero (registered)
underflow_err  out  1  sticky: a retire hit a zero counter

Behaviour:
- State: gcnt[GREG_N], fcnt[FREG_N], ecnt, each CNT_W bits; err flag.
- Reset (async, rst=1): all counters 0, err=0, busy=0, underflow_err=0. issue_stall is combinational and is 0 while counters are 0. Deassertion of rst is synchronised by the integrator, not here.
- Read hazard, combinational; any true term makes RAW=1:
  - from_gd & gcnt[d]!=0
  - from_fd & fcnt[d]!=0
  - from_gs & gcnt[s]!=0
  - from_fs & fcnt[s]!=0
  - from_gt & gcnt[t]!=0
  - from_ft & fcnt[t]!=0
  - from_ef & ecnt!=0
- Structural hazard, combinational; any true term makes FULL=1:
  - to_gd & gcnt[d]==max
  - to_fd & fcnt[d]==max
  - to_ef & ecnt==max
- issue_stall = issue_valid & (RAW | FULL) & ~flush.
- Counter update per cycle, for each register: next = cnt + inc - dec.
  - inc = accepted issue targeting that register (to_gd, to_fd or to_ef).
  - dec = matching wb valid and cnt!=0.
  - Same register inc and dec in the same cycle: counter unchanged.
  - Instruction reading and writing the same register (e.g. ADD d=s=3): hazard checked against the pre-issue count, so a self-dependency never stalls itself.
- Retire on a zero counter: counter stays 0, err set; err stays set until rst.
- Flush=1: next cycle all counters = 0. Same-cycle issue and wb are ignored; issue_stall forced 0. err unaffected.
- busy register = OR of all counters after update. It lags the counters by 0 cycles: it is computed from next-state and registered.
- Index widths: indices >= GREG_N / FREG_N are ignored for both hazard and update.
- Latency: without bypass, a retire clears the hazard on the following cycle (1-cycle stall minimum after wb).

Optional Feature:
SCOREBOARD_WB_BYPASS_EN
- Defined: read hazard terms use the counter minus same-cycle matching wb (effective count). A source whose last pending write retires this cycle does not stall; the issue is accepted that cycle. FULL uses the same effective count.
- Undefined: hazard uses the registered counter only, so a consumer stalls through the wb cycle and issues the cycle after.

Test Plan:
- ADD d=3 issued (to_gd) at cycle 0 -> gcnt[3]=1, busy=1 at cycle 1. ADDI s=3 presented at cycle 1 -> issue_stall=1. wb_gd idx=3 at cycle 2 -> stall=0 at cycle 3 (cycle 2 with bypass).
- Three MOVI d=5 issued back-to-back, no wb -> gcnt[5]=3; a fourth -> issue_stall=1 (FULL) until one wb idx=5.
- CMP (to_ef) then JE (from_ef) next cycle -> stall until wb_ef_valid; simultaneous issue of a to_ef and a wb_ef -> ecnt unchanged.
- gcnt[7]=2 and fcnt[1]=1, assert flush together with an issue_valid to_gd d=7 -> next cycle all counters 0, busy=0, issue not counted.
- wb_gd_valid idx=9 with gcnt[9]=0 -> gcnt[9] stays 0, underflow_err=1 and held; rst mid-operation with counters nonzero -> all counters 0 and err=0 immediately, without waiting for clk.
